kb_uart_sched: RTL and testbench
================================

# kb_uart_sched

Scan-code-to-UART scheduler for the PS/2 keyboard path. Sits between the PS/2 receiver (which delivers one scan byte per `rx_done_tick`) and the UART transmitter (`tx_start` / `tx_done_tick` handshake). Filters break sequences, translates make codes to ASCII, buffers characters in a small FIFO and issues one UART frame at a time.

## Interface
- `FIFO_AW`, 2, FIFO address width; depth = 2**FIFO_AW entries of 8 bits
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `rx_done_tick`  in  1  one-cycle pulse: `scan` holds a new scan byte
- `scan`  in  8  scan byte from the PS/2 receiver
- `tx_done_tick`  in  1  one-cycle pulse: UART finished the current frame
- `tx_start`  out  1  one-cycle pulse: start a UART frame with `tx_data`
- `tx_data`  out  8  ASCII byte to send; stable from `tx_start` until `tx_done_tick`
- `fifo_full`  out  1  FIFO holds 2**FIFO_AW entries
- `overflow`  out  1  one-cycle pulse: a character was dropped because the FIFO was full

## Operation
- Parser FSM, evaluated only on `rx_done_tick`:
  - MAKE: `scan`=F0h -> BRK, nothing queued. `scan`=E0h -> ignored, stay in MAKE. Any other byte -> translate and enqueue, stay in MAKE.
  - BRK: any byte other than F0h -> discarded, back to MAKE. F0h -> stay in BRK.
- Translation: 45h,16h,1Eh,26h,25h,2Eh,36h,3Dh,3Eh,46h -> '0'..'9' (30h..39h). Letter make codes -> 'a'..'z' (1Ch->61h, 32h->62h, 21h->63h, ... 1Ah->7Ah). 29h->20h. 5Ah->0Dh. Any other code -> 2Ah ('*').
- FIFO: write on translated character, pop on `tx_start`. A write while full with no same-cycle pop -> character dropped, `overflow` pulses, contents unchanged. Write and pop in the same cycle -> both take effect, count unchanged (also when full).
- TX FSM:
  - T_IDLE: FIFO non-empty -> pulse `tx_start`, latch head into `tx_data`, pop -> T_BUSY.
  - T_BUSY: `tx_done_tick` -> T_IDLE.
  - `tx_done_tick` in T_IDLE is ignored.
- Reset (any time, including mid-frame): parser -> MAKE, TX -> T_IDLE, FIFO empty, `tx_start`=0, `tx_data`=00h, `fifo_full`=0, `overflow`=0. A `tx_done_tick` from a UART frame interrupted by reset is ignored.

## Timing
- `rx_done_tick` in cycle N -> character written at the end of cycle N (visible in cycle N+1).
- If TX is in T_IDLE, `tx_start` is high in cycle N+2 (registered). Latency is 2 cycles.
- After `tx_done_tick` in cycle M, the next `tx_start` is no earlier than cycle M+2. T_IDLE spends at least one cycle.
- `fifo_full` and `overflow` are registered. `overflow` is high in cycle N+1 for a drop caused in cycle N.
- All outputs come from registers. There is no combinational path from input to output.

## Configuration
- `KB_SHIFT_EN` defined:
  - Parser tracks a shift flag: make 12h/59h sets it, break F0h+12h / F0h+59h clears it.
  - Shift make codes are never enqueued.
  - While shift is set, letters translate to upper case (1Ch -> 41h). Digits are unchanged.
- `KB_SHIFT_EN` undefined:
  - No shift flag exists.
  - 12h/59h translate to 2Ah like any unmapped code.

## Structure
- Shared package `kb_pkg`: scan constants (`SC_BREAK`=F0h, `SC_EXT`=E0h, `SC_LSHIFT`=12h, `SC_RSHIFT`=59h), the unmapped character `ASC_UNKNOWN`=2Ah, and the parser and TX state encodings.
- Sub-module `kb_key2ascii`: purely combinational translation with inputs scan[7:0] and shift, output ascii[7:0]. Synthesizable alone.
- FIFO stays inline as a register array with read/write pointers and a count.

## Test plan
- Make 45h, F0h, 45h with `tx_done_tick` returned 100 cycles after each `tx_start` -> exactly one `tx_start`, 2 cycles after the first tick, `tx_data`=30h. The break pair produces nothing.
- Make 1Ch, 32h, 21h back-to-back, UART slow -> three frames in order 61h, 62h, 63h, one per `tx_done_tick`, each ≥2 cycles apart.
- FIFO_AW=2, UART never completes, six make codes -> first character sent, next 4 buffered, `fifo_full`=1, one `overflow` pulse, sixth character dropped. Releasing `tx_done_tick` drains exactly 4 more.
- E0h, 75h -> one 2Ah frame. F0h, F0h, 45h -> no frame. Unmapped 07h -> 2Ah.
- Reset asserted mid-frame with 3 entries queued -> all outputs at reset values, FIFO empty. A stale `tx_done_tick` after release causes no `tx_start`.
- With `KB_SHIFT_EN`: 12h, 1Ch, F0h, 12h, 1Ch -> frames 41h then 61h. No frame for shift codes.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared constants and state encodings for the PS/2 scan-code to UART scheduler.
package kb_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] ASC_UNKNOWN = 8'h2A;

    typedef enum logic [0:0] {
        StMake,
        StBrk
    } parse_state_e;

    typedef enum logic [0:0] {
        StTxIdle,
        StTxBusy
    } tx_state_e;

    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/kb_key2ascii.sv
// Combinational PS/2 set-2 make code to ASCII translation; shift upper-cases letters only.
module kb_key2ascii
    import kb_pkg::*;
(
    input  logic [7:0] scan,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] base;
    logic       letter;

    always_comb begin
        base   = ASC_UNKNOWN;
        letter = 1'b1;
        case (scan)
            8'h1C: base = 8'h61;
            8'h32: base = 8'h62;
            8'h21: base = 8'h63;
            8'h23: base = 8'h64;
            8'h24: base = 8'h65;
            8'h2B: base = 8'h66;
            8'h34: base = 8'h67;
            8'h33: base = 8'h68;
            8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;
            8'h42: base = 8'h6B;
            8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;
            8'h31: base = 8'h6E;
            8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;
            8'h15: base = 8'h71;
            8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;
            8'h2C: base = 8'h74;
            8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;
            8'h1D: base = 8'h77;
            8'h22: base = 8'h78;
            8'h35: base = 8'h79;
            8'h1A: base = 8'h7A;
            default: begin
                letter = 1'b0;
                case (scan)
                    8'h45: base = 8'h30;
                    8'h16: base = 8'h31;
                    8'h1E: base = 8'h32;
                    8'h26: base = 8'h33;
                    8'h25: base = 8'h34;
                    8'h2E: base = 8'h35;
                    8'h36: base = 8'h36;
                    8'h3D: base = 8'h37;
                    8'h3E: base = 8'h38;
                    8'h46: base = 8'h39;
                    8'h29: base = 8'h20;
                    8'h5A: base = 8'h0D;
                    default: base = ASC_UNKNOWN;
                endcase
            end
        endcase
        // Lower to upper case is a fixed 20h offset in ASCII.
        ascii = (shift && letter) ? (base - 8'h20) : base;
    end

endmodule

// File: rtl/kb_uart_sched.sv
// Scan-byte parser, ASCII FIFO and one-frame-at-a-time UART scheduler.
// Optional shift tracking is enabled by defining KB_SHIFT_EN.
module kb_uart_sched
    import kb_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] scan,
    input  logic       tx_done_tick,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FullCount = (FIFO_AW + 1)'(Depth);

    parse_state_e       pstate_q;
    tx_state_e          tx_state_q;
    logic [7:0]         mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               shift_now;
    logic               shift_code;
    logic [7:0]         ascii;
    logic               wr_en, push, pop, drop, empty, full_now;

`ifdef KB_SHIFT_EN
    logic shift_q;
    assign shift_now  = shift_q;
    assign shift_code = is_shift_code(scan);
`else
    assign shift_now  = 1'b0;
    assign shift_code = 1'b0;
`endif

    kb_key2ascii u_key2ascii (
        .scan  (scan),
        .shift (shift_now),
        .ascii (ascii)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pstate_q <= StMake;
`ifdef KB_SHIFT_EN
            shift_q  <= 1'b0;
`endif
        end else if (rx_done_tick) begin
            case (pstate_q)
                StMake: begin
                    if (scan == SC_BREAK) begin
                        pstate_q <= StBrk;
                    end
`ifdef KB_SHIFT_EN
                    if (shift_code) begin
                        shift_q <= 1'b1;
                    end
`endif
                end
                StBrk: begin
                    if (scan != SC_BREAK) begin
                        pstate_q <= StMake;
`ifdef KB_SHIFT_EN
                        if (shift_code) begin
                            shift_q <= 1'b0;
                        end
`endif
                    end
                end
                default: pstate_q <= StMake;
            endcase
        end
    end

    assign wr_en = rx_done_tick && (pstate_q == StMake) && (scan != SC_BREAK) &&
                   (scan != SC_EXT) && !shift_code;

    assign empty    = (count_q == '0);
    assign full_now = (count_q == FullCount);
    assign pop      = (tx_state_q == StTxIdle) && !empty;
    // A same-cycle pop frees the slot, so a full FIFO can still accept the write.
    assign push     = wr_en && (!full_now || pop);
    assign drop     = wr_en && full_now && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ascii;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q   <= count_d;
            fifo_full <= (count_d == FullCount);
            overflow  <= drop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= StTxIdle;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (tx_state_q)
                StTxIdle: begin
                    if (!empty) begin
                        tx_start   <= 1'b1;
                        tx_data    <= mem_q[rd_ptr_q];
                        tx_state_q <= StTxBusy;
                    end
                end
                StTxBusy: begin
                    if (tx_done_tick) begin
                        tx_state_q <= StTxIdle;
                    end
                end
                default: tx_state_q <= StTxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_kb_uart_sched.sv
// Directed bench for kb_uart_sched: frame log, latency, FIFO overflow and reset behaviour.
module tb_kb_uart_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] scan;
    logic       tx_done_tick;
    logic       done_auto = 1'b0;
    logic       done_man;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       fifo_full;
    logic       overflow;

    int unsigned cyc = 0;
    int          uart_delay = 0;
    int          ovf_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  fr_data [$];
    int unsigned fr_cyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tx_done_tick = done_auto | done_man;

    kb_uart_sched #(.FIFO_AW(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .scan         (scan),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    always @(negedge clk) begin
        if (tx_start) begin
            fr_data.push_back(tx_data);
            fr_cyc.push_back(cyc);
        end
        if (overflow) ovf_cnt++;
    end

    // UART model: answers each frame uart_delay cycles after tx_start (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && uart_delay != 0) begin
                repeat (uart_delay) @(posedge clk);
                #1 done_auto = 1'b1;
                @(posedge clk);
                #1 done_auto = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        scan         = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1 rx_done_tick = 1'b0;
    endtask

    task automatic pulse_done();
        done_man = 1'b1;
        @(posedge clk);
        #1 done_man = 1'b0;
    endtask

    initial begin
        int nb;
        int ob;
        int unsigned t0;
        reset        = 1'b0;
        rx_done_tick = 1'b0;
        scan         = 8'h00;
        done_man     = 1'b0;
        idle(3);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1;
        idle(2);

        // Make 45h then a break pair: one '0' frame, two cycles after the tick.
        uart_delay = 100;
        nb = fr_data.size();
        t0 = cyc;
        send(8'h45);
        send(8'hF0);
        send(8'h45);
        idle(300);
        check("t1_count", fr_data.size(), nb + 1);
        check("t1_latency", fr_cyc[nb] - t0, 2);
        check("t1_data", fr_data[nb], 8'h30);

        // Three letters back-to-back, slow UART.
        uart_delay = 20;
        nb = fr_data.size();
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        idle(150);
        check("t2_count", fr_data.size(), nb + 3);
        check("t2_data0", fr_data[nb], 8'h61);
        check("t2_data1", fr_data[nb+1], 8'h62);
        check("t2_data2", fr_data[nb+2], 8'h63);
        check("t2_gap01", (fr_cyc[nb+1] - fr_cyc[nb]) >= 22, 1);
        check("t2_gap12", (fr_cyc[nb+2] - fr_cyc[nb+1]) >= 22, 1);

        // UART stalled: six digits, one sent, four buffered, one dropped.
        uart_delay = 0;
        idle(2);
        nb = fr_data.size();
        ob = ovf_cnt;
        send(8'h16);
        send(8'h1E);
        send(8'h26);
        send(8'h25);
        send(8'h2E);
        send(8'h36);
        idle(5);
        check("t3_first_count", fr_data.size(), nb + 1);
        check("t3_first_data", fr_data[nb], 8'h31);
        check("t3_full", fifo_full, 1);
        check("t3_overflow_pulses", ovf_cnt - ob, 1);
        for (int i = 0; i < 4; i++) begin
            pulse_done();
            idle(4);
        end
        check("t3_drain_count", fr_data.size(), nb + 5);
        check("t3_drain1", fr_data[nb+1], 8'h32);
        check("t3_drain2", fr_data[nb+2], 8'h33);
        check("t3_drain3", fr_data[nb+3], 8'h34);
        check("t3_drain4", fr_data[nb+4], 8'h35);
        check("t3_not_full", fifo_full, 0);
        pulse_done();
        idle(5);
        check("t3_no_sixth", fr_data.size(), nb + 5);

        // Extended prefix, double break, unmapped code.
        uart_delay = 5;
        nb = fr_data.size();
        send(8'hE0);
        send(8'h75);
        idle(20);
        check("t4_ext_count", fr_data.size(), nb + 1);
        check("t4_ext_data", fr_data[nb], 8'h2A);
        nb = fr_data.size();
        send(8'hF0);
        send(8'hF0);
        send(8'h45);
        idle(20);
        check("t4_dblbrk_count", fr_data.size(), nb);
        send(8'h07);
        idle(20);
        check("t4_unmapped_count", fr_data.size(), nb + 1);
        check("t4_unmapped_data", fr_data[nb], 8'h2A);

        // Reset mid-frame with three entries queued.
        uart_delay = 0;
        nb = fr_data.size();
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        idle(3);
        check("t5_sent_before_rst", fr_data.size(), nb + 1);
        reset = 1'b0;
        idle(1);
        check("t5_rst_tx_start", tx_start, 0);
        check("t5_rst_tx_data", tx_data, 8'h00);
        check("t5_rst_fifo_full", fifo_full, 0);
        check("t5_rst_overflow", overflow, 0);
        idle(1);
        reset = 1'b1;
        idle(3);
        pulse_done();
        idle(10);
        check("t5_stale_done", fr_data.size(), nb + 1);
        uart_delay = 5;
        t0 = cyc;
        send(8'h24);
        idle(20);
        check("t5_after_count", fr_data.size(), nb + 2);
        check("t5_after_data", fr_data[nb+1], 8'h65);
        check("t5_after_latency", fr_cyc[nb+1] - t0, 2);

        // Shift handling.
        uart_delay = 5;
        nb = fr_data.size();
`ifdef KB_SHIFT_EN
        send(8'h12);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        send(8'h1C);
        idle(40);
        check("t6_count", fr_data.size(), nb + 2);
        check("t6_upper", fr_data[nb], 8'h41);
        check("t6_lower", fr_data[nb+1], 8'h61);
`else
        send(8'h12);
        idle(15);
        send(8'h59);
        idle(15);
        check("t6_count", fr_data.size(), nb + 2);
        check("t6_lshift", fr_data[nb], 8'h2A);
        check("t6_rshift", fr_data[nb+1], 8'h2A);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
